// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and PHY register constants for the MIIM sequencer.
//   miim_state_t - top-level sequencing states
//   acc_state_t  - single-access handshake engine states
//   BMCR/BMSR register addresses and the bit patterns written/tested
package mdio_pkg;

  typedef enum logic [2:0] {
    ST_RST_WAIT,
    ST_WR_RST,
    ST_RD_RST,
    ST_WR_CFG,
    ST_IDLE,
    ST_POLL,
    ST_USER,
    ST_ERROR
  } miim_state_t;

  typedef enum logic [1:0] {
    A_IDLE,
    A_ISSUE,
    A_WAIT_HI,
    A_WAIT_LO
  } acc_state_t;

  localparam logic [4:0]  BMCR           = 5'd0;
  localparam logic [4:0]  BMSR           = 5'd1;
  localparam logic [15:0] BMCR_RESET     = 16'h8000;
  localparam logic [15:0] BMCR_CFG_10FD  = 16'h0100;
  localparam int          BMCR_RESET_BIT = 15;
  localparam int          BMSR_LINK_BIT  = 2;

endpackage

// File: rtl/miim_access.sv
// miim_access: one MIIM register access (read or write) with timeout.
//   start/we/regad/wrdata - request, sampled while idle
//   tmr_keep              - keep the running timeout count for this start
//   idle                  - ready to accept start
//   done                  - completion, combinational, one cycle
//   timeout               - wait budget exhausted, combinational, one cycle
//   rddata                - read data, valid with done on a read
//   miim_*                - MAC MIIM port (strobes/address/data registered)
module miim_access import mdio_pkg::*; #(
  parameter int TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        we,
  input  logic        tmr_keep,
  input  logic [4:0]  regad,
  input  logic [15:0] wrdata,
  output logic        idle,
  output logic        done,
  output logic        timeout,
  output logic [15:0] rddata,
  output logic        miim_wren,
  output logic        miim_rden,
  output logic [4:0]  miim_regad,
  output logic [15:0] miim_wrdata,
  input  logic        miim_busy,
  input  logic [15:0] miim_rddata,
  input  logic        miim_rddata_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);

  acc_state_t    st_q, st_d;
  logic          we_q;
  logic [TW-1:0] tcnt_q;
  logic          fire;

  assign idle    = (st_q == A_IDLE);
  assign done    = (st_q == A_WAIT_LO) && (we_q ? !miim_busy : miim_rddata_valid);
  assign timeout = (st_q != A_IDLE) && (tcnt_q == T_MAX) && !done;
  assign rddata  = miim_rddata;
  // Strobe goes out on the same edge the request is latched when the MAC is free.
  assign fire    = ((idle && start) || (st_q == A_ISSUE)) && !miim_busy && !timeout;

  always_ff @(posedge clk) begin
    if (!reset) st_q <= A_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      A_IDLE:    if (start) st_d = miim_busy ? A_ISSUE : A_WAIT_HI;
      A_ISSUE:   if (!miim_busy) st_d = A_WAIT_HI;
      A_WAIT_HI: if (miim_busy) st_d = A_WAIT_LO;
      A_WAIT_LO: if (done) st_d = A_IDLE;
      default:   st_d = A_IDLE;
    endcase
    if (timeout) st_d = A_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      miim_wren   <= 1'b0;
      miim_rden   <= 1'b0;
      miim_regad  <= '0;
      miim_wrdata <= '0;
      we_q        <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      miim_wren <= 1'b0;
      miim_rden <= 1'b0;
      if (idle) begin
        if (start) begin
          miim_regad  <= regad;
          miim_wrdata <= wrdata;
          we_q        <= we;
          if (!tmr_keep) tcnt_q <= '0;
        end
      end else if (tcnt_q != T_MAX) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (fire) begin
        miim_wren <= idle ? we  : we_q;
        miim_rden <= idle ? !we : !we_q;
      end
    end
  end

endmodule

// File: rtl/miim_sequencer.sv
// miim_sequencer: boots the PHY (soft reset, wait, force 10M full duplex),
// then polls BMSR link status and arbitrates user register accesses onto
// the MAC MIIM port.
//   clk, reset (sync, active-low)
//   miim_*     - MAC MIIM request port
//   usr_*      - single-register user access (req held until ack)
//   init_done  - configuration written (sticky)
//   link_up    - BMSR link bit from the last poll
//   error      - sticky wait timeout
module miim_sequencer import mdio_pkg::*; #(
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter int         RST_WAIT      = 500000,
  parameter int         POLL_INTERVAL = 1000000,
  parameter int         TIMEOUT       = 100000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [4:0]  miim_phyad,
  output logic [4:0]  miim_regad,
  output logic [15:0] miim_wrdata,
  output logic        miim_wren,
  output logic        miim_rden,
  input  logic        miim_busy,
  input  logic [15:0] miim_rddata,
  input  logic        miim_rddata_valid,
  input  logic        usr_req,
  input  logic        usr_we,
  input  logic [4:0]  usr_regad,
  input  logic [15:0] usr_wrdata,
  output logic        usr_ack,
  output logic [15:0] usr_rddata,
  output logic        init_done,
  output logic        link_up,
  output logic        error
);

  localparam int RW = $clog2(RST_WAIT + 1);
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_WAIT - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_INTERVAL - 1);
  localparam logic [PW-1:0] POLL_TERM = PW'(POLL_INTERVAL);

  miim_state_t state_q, state_d;
  logic [RW-1:0] rst_cnt_q;
  logic [PW-1:0] poll_cnt_q;
  logic          rd_again_q;
  logic          usr_we_q;
  logic [4:0]    usr_regad_q;
  logic [15:0]   usr_wrdata_q;

  logic          acc_start, acc_we, acc_idle, acc_done, acc_timeout;
  logic [4:0]    acc_regad;
  logic [15:0]   acc_wrdata, acc_rddata;

  assign miim_phyad = PHY_ADDR;
  assign acc_start  = acc_idle &&
                      (state_q inside {ST_WR_RST, ST_RD_RST, ST_WR_CFG, ST_POLL, ST_USER});

  always_comb begin
    acc_we     = 1'b0;
    acc_regad  = BMCR;
    acc_wrdata = '0;
    case (state_q)
      ST_WR_RST: begin acc_we = 1'b1; acc_wrdata = BMCR_RESET;    end
      ST_WR_CFG: begin acc_we = 1'b1; acc_wrdata = BMCR_CFG_10FD; end
      ST_POLL:   acc_regad = BMSR;
      ST_USER: begin
        acc_we     = usr_we_q;
        acc_regad  = usr_regad_q;
        acc_wrdata = usr_wrdata_q;
      end
      default: ;
    endcase
  end

  miim_access #(.TIMEOUT(TIMEOUT)) u_access (
    .clk               (clk),
    .reset             (reset),
    .start             (acc_start),
    .we                (acc_we),
    .tmr_keep          (rd_again_q),
    .regad             (acc_regad),
    .wrdata            (acc_wrdata),
    .idle              (acc_idle),
    .done              (acc_done),
    .timeout           (acc_timeout),
    .rddata            (acc_rddata),
    .miim_wren         (miim_wren),
    .miim_rden         (miim_rden),
    .miim_regad        (miim_regad),
    .miim_wrdata       (miim_wrdata),
    .miim_busy         (miim_busy),
    .miim_rddata       (miim_rddata),
    .miim_rddata_valid (miim_rddata_valid)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RST_WAIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST_WAIT: if (rst_cnt_q == RST_LAST) state_d = ST_WR_RST;
      ST_WR_RST:   if (acc_done) state_d = ST_RD_RST;
      ST_RD_RST:   if (acc_done && !acc_rddata[BMCR_RESET_BIT]) state_d = ST_WR_CFG;
      ST_WR_CFG:   if (acc_done) state_d = ST_IDLE;
      // User wins a tie; the interval counter stays at terminal count so
      // the poll follows as soon as the user access returns.
      ST_IDLE: begin
        if (usr_req)                     state_d = ST_USER;
        else if (poll_cnt_q >= POLL_LAST) state_d = ST_POLL;
      end
      ST_POLL, ST_USER: if (acc_done) state_d = ST_IDLE;
      default: ;
    endcase
    if (acc_timeout) state_d = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_cnt_q    <= '0;
      poll_cnt_q   <= '0;
      rd_again_q   <= 1'b0;
      usr_we_q     <= 1'b0;
      usr_regad_q  <= '0;
      usr_wrdata_q <= '0;
      usr_ack      <= 1'b0;
      usr_rddata   <= '0;
      init_done    <= 1'b0;
      link_up      <= 1'b0;
      error        <= 1'b0;
    end else begin
      usr_ack <= 1'b0;
      if (state_q == ST_RST_WAIT) rst_cnt_q <= rst_cnt_q + 1'b1;
      // Repeated BMCR reads share one timeout budget.
      rd_again_q <= (state_q == ST_RD_RST) &&
                    (rd_again_q || (acc_done && acc_rddata[BMCR_RESET_BIT]));
      if (state_q == ST_WR_CFG && acc_done) init_done <= 1'b1;
      if (state_q == ST_IDLE) begin
        if (poll_cnt_q != POLL_TERM) poll_cnt_q <= poll_cnt_q + 1'b1;
        if (usr_req) begin
          usr_we_q     <= usr_we;
          usr_regad_q  <= usr_regad;
          usr_wrdata_q <= usr_wrdata;
        end
      end
      if (state_q == ST_POLL && acc_done) begin
        link_up    <= acc_rddata[BMSR_LINK_BIT];
        poll_cnt_q <= '0;
      end
      if (state_q == ST_USER && acc_done) begin
        usr_ack <= 1'b1;
        if (!usr_we_q) usr_rddata <= acc_rddata;
      end
      if (state_d == ST_ERROR) begin
        error   <= 1'b1;
        link_up <= 1'b0;
      end
    end
  end

endmodule

// File: doc/miim_sequencer.md
# miim_sequencer

Management-plane controller that drives the MAC core's MIIM (MDIO) request port. After reset it soft-resets the PHY, waits for the PHY reset to complete, and forces the PHY to 10 Mb/s full duplex with auto-negotiation off. It then polls link status periodically and multiplexes single-register user accesses onto the same MIIM port. It sits between the bridge's control logic and the MAC wrapper's `miim_*` pins, in the `clk` domain.

## Interface
- `PHY_ADDR`, 5'd1: PHY address driven on `miim_phyad` for every access.
- `RST_WAIT`, 500000: idle cycles after reset release before the first access.
- `POLL_INTERVAL`, 1000000: cycles between link-status reads in IDLE.
- `TIMEOUT`, 100000: maximum cycles in any one wait state before entering ERROR.
- `clk` in 1: system clock, shared with the MAC MIIM port.
- `reset` in 1: synchronous, active-low.
- `miim_phyad` out 5: PHY address (constant `PHY_ADDR`).
- `miim_regad` out 5: register address.
- `miim_wrdata` out 16: write data.
- `miim_wren` out 1: one-cycle write strobe.
- `miim_rden` out 1: one-cycle read strobe.
- `miim_busy` in 1: MAC MIIM engine busy.
- `miim_rddata` in 16: read data.
- `miim_rddata_valid` in 1: one-cycle read-data qualifier.
- `usr_req` in 1: user access request; held until `usr_ack`.
- `usr_we` in 1: 1 = write, 0 = read.
- `usr_regad` in 5: user register address.
- `usr_wrdata` in 16: user write data.
- `usr_ack` out 1: one-cycle completion pulse.
- `usr_rddata` out 16: read result, valid with `usr_ack`; holds until the next read.
- `init_done` out 1: high once configuration is written; sticky until reset.
- `link_up` out 1: BMSR bit 2 from the last completed poll.
- `error` out 1: sticky timeout flag.

## Operation
- States: RST_WAIT → WR_RST → RD_RST → WR_CFG → IDLE ⇄ {POLL, USER}; any wait timeout → ERROR.
- **Access primitive:**
  - When `miim_busy`=0, pulse `wren`/`rden` for exactly one cycle with `regad`/`wrdata` stable.
  - Wait for `miim_busy`=1, then for `miim_busy`=0.
  - A read completes on the `miim_rddata_valid` pulse; data is captured that cycle.
  - Address and data stay stable until the access completes.
- **RST_WAIT:** count `RST_WAIT` cycles.
- **WR_RST:** write reg 0 = 16'h8000.
- **RD_RST:** read reg 0 repeatedly until bit 15 = 0.
- **WR_CFG:** write reg 0 = 16'h0100 (speed bits 13/6 = 0, duplex bit 8 = 1, ANEN bit 12 = 0). Set `init_done` on completion.
- **IDLE:**
  - The interval counter counts up to `POLL_INTERVAL`.
  - If `usr_req` is high, go to USER. User has priority over a poll due in the same cycle; the poll then runs immediately after USER.
  - Otherwise, when the counter expires, go to POLL.
- **POLL:** read reg 1; `link_up` ← bit 2; return to IDLE; counter cleared.
- **USER:** perform the access with a `usr_*` snapshot taken at entry; pulse `usr_ack`; return to IDLE.
- `usr_req` is ignored (never acked) before `init_done` and in ERROR.
- **ERROR:** strobes stay low, `error`=1, `link_up`=0. Exit only via reset.

## Timing
- Reset values: all strobes 0, `miim_regad`/`miim_wrdata`/`usr_rddata` 0, `miim_phyad`=`PHY_ADDR`, `usr_ack`/`init_done`/`link_up`/`error` 0, state RST_WAIT, counters 0.
- All outputs are registered.
- The first strobe asserts on cycle `RST_WAIT`+1 after `reset` rises, if `miim_busy`=0.
- `usr_ack` is asserted the cycle after `rddata_valid` (read) or after `busy` falls (write).
- Minimum user latency is `usr_req` → strobe in 2 cycles.
- The timeout counter resets on each state entry. It saturates at `TIMEOUT` and triggers ERROR on the next cycle. RD_RST shares one timeout across all of its iterations.
- If `busy` never rises after a strobe, the timeout applies.
- Reset asserted mid-access aborts immediately; the next cycle shows reset values.
- The interval counter is 20+ bits wide (`$clog2(POLL_INTERVAL+1)`) and does not wrap. It holds at terminal count while USER is active.

## Structure
- Package `mdio_pkg`:
  - State enum `miim_state_t`.
  - Register constants: `BMCR`=5'd0, `BMSR`=5'd1, `BMCR_RESET`=16'h8000, `BMCR_CFG_10FD`=16'h0100, `BMSR_LINK_BIT`=2.
- Sub-module `miim_access`: the single-access handshake engine.
  - Inputs: start, we, regad, wrdata.
  - Outputs: done, rddata.
  - Contains the timeout.
- The top level holds the sequencing FSM, the arbitration and the interval counter.

## Test plan
- **Boot:** MAC model returns reg 0 = 16'h8000 twice, then 16'h0000. Expect the write of 8000, three reads, then the write of 0100; `init_done`=1.
- **Link poll:** BMSR = 16'h7809 then 16'h780D. Expect `link_up` 0 then 1 on successive polls spaced `POLL_INTERVAL`.
- **User read** of reg 2 returning 16'h0022: `usr_ack` one cycle, `usr_rddata`=16'h0022, `miim_phyad`=`PHY_ADDR`.
- **Collision:** `usr_req` in the same cycle the poll expires. Expect the user access first, the poll immediately after, and no dropped request.
- **Timeout:** `busy` stuck at 1 after the WR_CFG strobe. Expect `error`=1 after `TIMEOUT` cycles and `init_done`=0.
- **Mid-access reset:** reset during a user read. Expect all outputs at reset values the next cycle, and the boot sequence restarts.
